// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/ready stages with stall propagation,
// bubble collapsing, synchronous flush and synchronous active-low reset.
module pipe_reg_elastic #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  count
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // A stage can load if the output drains or any stage at or
            // downstream of it is empty; written flat to avoid a ripple loop.
            assign rdy[gi] = out_ready | ~(&v_q[DEPTH-1:gi]);

            if (gi == 0) begin : g_head
                assign src_v[gi]    = in_valid & ~flush;
                assign src_data[gi] = in_data;
            end else begin : g_body
                assign src_v[gi]    = v_q[gi-1];
                assign src_data[gi] = data_q[gi-1];
            end
        end
    endgenerate

    assign in_ready = rdy[0] & ~flush & clr_n;

    // Flush clears only the valid bits; stale data is harmless behind v=0.
    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i]    = src_v[i];
                data_d[i] = src_data[i];
            end
        end
    end

    assign count_d = CNTW'($countones(v_d));

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: three instances (DEPTH 3, 4, 2) driven
// from one linear stimulus sequence with immediate-assertion checks.
module tb_pipe_reg_elastic;

    logic clk;
    logic rst_n;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [64:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_count;

    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0]  c_in_data, c_out_data;
    logic [1:0]  c_count;

    int checks = 0;
    int errors = 0;

    pipe_reg_elastic #(.WIDTH(65), .DEPTH(3)) u_a (
        .clock(clk), .clr_n(rst_n), .flush(a_flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .count(a_count)
    );

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(4)) u_b (
        .clock(clk), .clr_n(rst_n), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .count(b_count)
    );

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(2)) u_c (
        .clock(clk), .clr_n(rst_n), .flush(c_flush),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 65'h1_0000_0000_DEAD_BEEF; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;

        // Reset held two edges with in_valid asserted
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("rst_out_valid", a_out_valid, 0);
            chk("rst_out_data", a_out_data, 0);
            chk("rst_count", a_count, 0);
            chk("rst_in_ready", a_in_ready, 0);
        end
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        #1;
        chk("rst_release_in_ready", a_in_ready, 1);
        $display("reset: done");

        // Streaming 1..10 with out_ready=1
        for (int n = 1; n <= 13; n++) begin
            a_in_valid = (n <= 10);
            a_in_data  = 65'(n);
            #1;
            if (n <= 10) chk("stream_in_ready", a_in_ready, 1);
            tick();
            exp_cnt = ((n < 10) ? n : 10) - ((n > 3) ? n - 3 : 0);
            chk("stream_out_valid", a_out_valid, (n >= 3 && n <= 12) ? 1 : 0);
            if (n >= 3 && n <= 12) chk("stream_out_data", a_out_data, 128'(n - 2));
            chk("stream_count", a_count, 128'(exp_cnt));
            $display("stream cycle %0d: out_valid=%0d out_data=%0h count=%0d",
                     n, a_out_valid, a_out_data, a_count);
        end

        // Stall/fill: out_ready=0, offer 5 words, 3 accepted
        a_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 65'(32'h11 + k);
            #1;
            chk("fill_in_ready", a_in_ready, (k < 3) ? 1 : 0);
            tick();
            chk("fill_count", a_count, (k < 2) ? 128'(k + 1) : 128'd3);
            if (k >= 2) begin
                chk("fill_out_valid", a_out_valid, 1);
                chk("fill_out_data_stable", a_out_data, 128'h11);
            end
            $display("fill offer %0d: count=%0d out_data=%0h", k, a_count, a_out_data);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        chk("full_drain_in_ready", a_in_ready, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("drain_out_valid", a_out_valid, (j < 2) ? 1 : 0);
            if (j < 2) chk("drain_out_data", a_out_data, 128'(32'h12 + j));
            chk("drain_count", a_count, 128'(2 - j));
            $display("drain %0d: out_valid=%0d out_data=%0h", j, a_out_valid, a_out_data);
        end

        // Flush with 3 valid entries and an offered 0xFF
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 65'(32'h21 + k);
            tick();
        end
        chk("preflush_count", a_count, 3);
        a_flush = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 65'hFF;
        #1;
        chk("flush_in_ready", a_in_ready, 0);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("flush_count", a_count, 0);
        chk("flush_out_valid", a_out_valid, 0);
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postflush_out_valid", a_out_valid, 0);
        end
        $display("flush: count=%0d out_valid=%0d", a_count, a_out_valid);

        // Reset with entries in flight
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 65'(32'h31 + k);
            tick();
        end
        chk("prereset_out_data", a_out_data, 128'h31);
        rst_n = 1'b0;
        a_in_data = 65'h99;
        a_out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", a_in_ready, 0);
        tick();
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_data", a_out_data, 0);
        chk("midrst_count", a_count, 0);
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        #1;
        chk("midrst_release_in_ready", a_in_ready, 1);
        $display("mid-transfer reset: out_data=%0h count=%0d", a_out_data, a_count);

        // Bubble collapse on DEPTH=4: words at cycles 0 and 2, out stalled
        b_out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            b_in_valid = (cyc == 0 || cyc == 2);
            b_in_data  = (cyc == 0) ? 8'hA1 : 8'hA2;
            tick();
            chk("bubble_out_valid", b_out_valid, (cyc == 3) ? 1 : 0);
        end
        b_in_valid = 1'b0;
        chk("bubble_out_data", b_out_data, 128'hA1);
        chk("bubble_count", b_count, 2);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bubble_hold_count", b_count, 2);
            chk("bubble_hold_data", b_out_data, 128'hA1);
        end
        b_out_ready = 1'b1;
        tick();
        chk("bubble_packed_data", b_out_data, 128'hA2);
        chk("bubble_packed_valid", b_out_valid, 1);
        chk("bubble_packed_count", b_count, 1);
        tick();
        chk("bubble_empty_valid", b_out_valid, 0);
        chk("bubble_empty_count", b_count, 0);
        $display("bubble collapse: count=%0d", b_count);

        // Simultaneous in/out on a full DEPTH=2 pipe
        c_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = 8'hC1 + 8'(k);
            tick();
        end
        #1;
        chk("c_full_in_ready", c_in_ready, 0);
        chk("c_full_count", c_count, 2);
        chk("c_full_out_data", c_out_data, 128'hC1);
        c_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = 8'hC3 + 8'(k);
            #1;
            chk("c_simul_in_ready", c_in_ready, 1);
            tick();
            chk("c_simul_count", c_count, 2);
            chk("c_simul_out_data", c_out_data, 128'(8'hC2 + 8'(k)));
            $display("simul cycle %0d: out_data=%0h count=%0d", k, c_out_data, c_count);
        end
        c_in_valid = 1'b0;
        tick();
        chk("c_tail_out_data", c_out_data, 128'hC6);
        chk("c_tail_count", c_count, 1);
        tick();
        chk("c_empty_out_valid", c_out_valid, 0);
        chk("c_empty_count", c_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
